// File: rtl/sha_frame_pkg.sv
// Shared constants, state encoding and helpers for the SHA-256 frame controller.
package sha_frame_pkg;

    localparam logic [7:0] SOF      = 8'h01;
    localparam logic [7:0] EOF      = 8'hFF;
    localparam logic [7:0] ESC      = 8'h7D;
    localparam logic [7:0] ESC_XOR  = 8'h20;
    localparam logic [7:0] PAD_BYTE = 8'h80;

    localparam logic [5:0] LAST_IDX = 6'd63;
    localparam logic [5:0] LEN_IDX  = 6'd56;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_HASH    = 3'd2,
        ST_PAD     = 3'd3,
        ST_SEND    = 3'd4
    } frame_state_t;

    // Picks byte sel (0 = most significant) of the 64-bit big-endian length field.
    function automatic logic [7:0] len_byte(input logic [63:0] bit_len, input logic [2:0] sel);
        logic [7:0] b;
        b = bit_len[{3'd7 - sel, 3'b000} +: 8];
        return b;
    endfunction

endpackage

// File: rtl/sha_digest_ser.sv
// Latches the final hash state and streams it out MSB-first over a valid/ready byte link.
module sha_digest_ser (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [255:0] digest_i,
    input  logic         tx_ready_i,
    output logic         tx_valid_o,
    output logic [7:0]   tx_data_o,
    output logic         last_o
);

    logic [255:0] dig_q;
    logic [4:0]   cnt_q;
    logic         valid_q;
    logic         fire_s;

    assign fire_s     = valid_q & tx_ready_i;
    assign last_o     = fire_s & (cnt_q == 5'd31);
    assign tx_valid_o = valid_q;
    assign tx_data_o  = dig_q[255:248];

    // Digest shift register and byte counter; the top byte is always the one on offer.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dig_q   <= 256'h0;
            cnt_q   <= 5'd0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            dig_q   <= digest_i;
            cnt_q   <= 5'd0;
            valid_q <= 1'b1;
        end else if (fire_s) begin
            dig_q   <= {dig_q[247:0], 8'h00};
            cnt_q   <= cnt_q + 5'd1;
            valid_q <= (cnt_q != 5'd31);
        end
    end

endmodule

// File: rtl/sha_frame_ctrl.sv
// UART frame parser, SHA-256 padder/block sequencer and digest streamer.
// Optional build macro SHA_FRAME_ESC_EN enables 0x7D byte-stuffing inside frames.
module sha_frame_ctrl
    import sha_frame_pkg::*;
#(
    parameter int unsigned LEN_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [7:0]   rx_data,
    output logic         rx_ready,
    output logic         core_start,
    output logic         core_init,
    output logic [511:0] core_block,
    input  logic         core_done,
    input  logic [255:0] core_digest,
    output logic         tx_valid,
    output logic [7:0]   tx_data,
    input  logic         tx_ready,
    output logic         busy,
    output logic         err
);

    frame_state_t     state_q, state_d;
    frame_state_t     ret_q, ret_d;
    logic [5:0]       idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             first_q, first_d;
    logic             marked_q, marked_d;
    logic             final_q, final_d;
    logic             err_q, err_d;
    logic [511:0]     buf_q;

    logic             rx_ready_q, rx_ready_d;
    logic             core_start_q, core_start_d;
    logic             core_init_q, core_init_d;
    logic             busy_q, busy_d;

    logic             wr_en_s;
    logic [5:0]       wr_idx_s;
    logic [7:0]       wr_byte_s;
    logic             rx_fire_s;
    logic             is_eof_s;
    logic             is_pay_s;
    logic [7:0]       pay_byte_s;
    logic [63:0]      len_bits_s;
    logic             dig_load_s;
    logic             ser_last_s;

    assign rx_fire_s  = rx_valid & rx_ready_q;
    assign len_bits_s = 64'(len_q) << 3'd3;
    assign dig_load_s = (state_q == ST_HASH) & core_done & (ret_q == ST_SEND);

`ifdef SHA_FRAME_ESC_EN
    logic esc_q, esc_d;
    logic esc_set_s;

    assign is_eof_s   = !esc_q && (rx_data == EOF);
    assign esc_set_s  = !esc_q && (rx_data == ESC);
    assign is_pay_s   = !is_eof_s && !esc_set_s;
    assign pay_byte_s = esc_q ? (rx_data ^ ESC_XOR) : rx_data;
`else
    assign is_eof_s   = (rx_data == EOF);
    assign is_pay_s   = !is_eof_s;
    assign pay_byte_s = rx_data;
`endif

    // State, frame bookkeeping and block buffer registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q  <= ST_IDLE;
            ret_q    <= ST_IDLE;
            idx_q    <= 6'd0;
            len_q    <= '0;
            first_q  <= 1'b0;
            marked_q <= 1'b0;
            final_q  <= 1'b0;
            err_q    <= 1'b0;
            buf_q    <= 512'h0;
`ifdef SHA_FRAME_ESC_EN
            esc_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ret_q    <= ret_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            first_q  <= first_d;
            marked_q <= marked_d;
            final_q  <= final_d;
            err_q    <= err_d;
`ifdef SHA_FRAME_ESC_EN
            esc_q    <= esc_d;
`endif
            if (wr_en_s) begin
                buf_q[{LAST_IDX - wr_idx_s, 3'b000} +: 8] <= wr_byte_s;
            end
        end
    end

    // Next-state and datapath decisions.
    always_comb begin
        state_d   = state_q;
        ret_d     = ret_q;
        idx_d     = idx_q;
        len_d     = len_q;
        first_d   = first_q;
        marked_d  = marked_q;
        final_d   = final_q;
        err_d     = 1'b0;
        wr_en_s   = 1'b0;
        wr_idx_s  = idx_q;
        wr_byte_s = 8'h00;
`ifdef SHA_FRAME_ESC_EN
        esc_d     = rx_fire_s ? esc_set_s : esc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rx_fire_s && (rx_data == SOF)) begin
                    state_d = ST_COLLECT;
                    idx_d   = 6'd0;
                    len_d   = '0;
                    first_d = 1'b1;
`ifdef SHA_FRAME_ESC_EN
                    esc_d   = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (rx_fire_s && is_pay_s) begin
                    if (&len_q) begin
                        // Length field would wrap: abandon the frame.
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        wr_en_s   = 1'b1;
                        wr_byte_s = pay_byte_s;
                        idx_d     = idx_q + 6'd1;
                        len_d     = len_q + LEN_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_HASH;
                            ret_d   = ST_COLLECT;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end
                end else if (rx_fire_s && is_eof_s) begin
                    state_d  = ST_PAD;
                    marked_d = 1'b0;
                    final_d  = (idx_q < LEN_IDX);
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_HASH: begin
                if (core_done) begin
                    first_d = 1'b0;
                    idx_d   = 6'd0;
                    state_d = ret_q;
                    final_d = final_q | (ret_q == ST_PAD);
                end else begin
                    state_d = ST_HASH;
                end
            end
            ST_PAD: begin
                wr_en_s  = 1'b1;
                marked_d = 1'b1;
                idx_d    = idx_q + 6'd1;
                if (!marked_q) begin
                    wr_byte_s = PAD_BYTE;
                end else if (final_q && (idx_q >= LEN_IDX)) begin
                    wr_byte_s = len_byte(len_bits_s, idx_q[2:0]);
                end else begin
                    wr_byte_s = 8'h00;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = ST_HASH;
                    ret_d   = final_q ? ST_SEND : ST_PAD;
                end else begin
                    state_d = ST_PAD;
                end
            end
            ST_SEND: begin
                if (ser_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Registered-output next values, derived from the upcoming state.
    always_comb begin
        rx_ready_d   = (state_d == ST_IDLE) || (state_d == ST_COLLECT);
        core_start_d = (state_d == ST_HASH) && (state_q != ST_HASH);
        core_init_d  = core_start_d & first_q;
        busy_d       = (state_d != ST_IDLE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            rx_ready_q   <= 1'b0;
            core_start_q <= 1'b0;
            core_init_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            rx_ready_q   <= rx_ready_d;
            core_start_q <= core_start_d;
            core_init_q  <= core_init_d;
            busy_q       <= busy_d;
        end
    end

    sha_digest_ser u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (dig_load_s),
        .digest_i   (core_digest),
        .tx_ready_i (tx_ready),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .last_o     (ser_last_s)
    );

    assign rx_ready   = rx_ready_q;
    assign core_start = core_start_q;
    assign core_init  = core_init_q;
    assign core_block = buf_q;
    assign busy       = busy_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sha_frame_ctrl.sv
// Directed bench for sha_frame_ctrl using a behavioural stand-in for the compression core.
module tb_sha_frame_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_valid, rx_ready;
    logic [7:0]   rx_data;
    logic         core_start, core_init, core_done;
    logic [511:0] core_block;
    logic [255:0] core_digest;
    logic         tx_valid, tx_ready, busy, err;
    logic [7:0]   tx_data;

    logic         rx_valid2, rx_ready2, core_start2, core_init2, tx_valid2, busy2, err2;
    logic [7:0]   rx_data2, tx_data2;
    logic [511:0] core_block2;
    logic         core_done2, tx_ready2;
    logic [255:0] core_digest2;

    logic [255:0] dig_in;
    logic         done_m = 1'b0;
    logic         inj_done;
    int           lat = 0;
    int           n_start = 0;
    int           stab_bad = 0;
    int           err_cnt = 0;
    int           start2_cnt = 0;
    int           cyc = 0;
    int           last_acc;
    logic [511:0] blk_cap [64];
    logic         init_cap [64];
    int           start_cyc [64];
    logic [511:0] cur_blk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [63:0]  pre;
        int           npre;
        logic [63:0]  msg;
        int           n;
        int           k;
        logic [511:0] blk;
        logic [255:0] dig;
        int           stall;
    } vec_t;
    vec_t vecs [5];

    sha_frame_ctrl #(.LEN_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .core_start(core_start), .core_init(core_init), .core_block(core_block),
        .core_done(core_done), .core_digest(core_digest),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .busy(busy), .err(err)
    );

    sha_frame_ctrl #(.LEN_W(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid2), .rx_data(rx_data2), .rx_ready(rx_ready2),
        .core_start(core_start2), .core_init(core_init2), .core_block(core_block2),
        .core_done(core_done2), .core_digest(core_digest2),
        .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready2), .busy(busy2), .err(err2)
    );

    always #5 clk = ~clk;

    assign core_done   = done_m | inj_done;
    assign core_digest = dig_in;

    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in compression core: fixed latency, records every block it is handed.
    always @(posedge clk) begin
        done_m <= 1'b0;
        if (core_start) begin
            blk_cap[n_start]   <= core_block;
            init_cap[n_start]  <= core_init;
            start_cyc[n_start] <= cyc;
            cur_blk            <= core_block;
            n_start            <= n_start + 1;
            lat                <= 4;
        end else if (lat != 0) begin
            lat <= lat - 1;
            if (lat == 1) done_m <= 1'b1;
        end
        if (done_m && (core_block !== cur_blk)) stab_bad <= stab_bad + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (core_start2) start2_cnt <= start2_cnt + 1;
    end

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        rx_valid = 1'b1;
        rx_data  = b;
        t = 0;
        while (!rx_ready && t < 2000) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 2000) begin
            checks++; errors++;
            $display("FAIL rx_timeout byte=%0h rx_ready=%0b", b, rx_ready);
        end
        @(posedge clk); #1;
        last_acc = cyc;
        rx_valid = 1'b0;
    endtask

    task automatic recv_digest(input string nm, input logic [255:0] exp, input int stall_at);
        int t;
        logic [7:0] hold;
        logic bad;
        logic [255:0] got;
        bad = 1'b0;
        got = 256'h0;
        tx_ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            t = 0;
            while (!tx_valid && t < 600) begin
                @(posedge clk); #1; t++;
            end
            got = {got[247:0], tx_data};
            if (i == stall_at) begin
                tx_ready = 1'b0;
                hold = tx_data;
                for (int s = 0; s < 10; s++) begin
                    @(posedge clk); #1;
                    if (tx_data !== hold || tx_valid !== 1'b1) bad = 1'b1;
                end
                tx_ready = 1'b1;
            end
            @(posedge clk); #1;
        end
        tx_ready = 1'b0;
        chk({nm, "_digest"}, got, exp);
        chk({nm, "_idle_after"}, {tx_valid, busy}, 2'b00);
        if (stall_at >= 0) chk({nm, "_stall_hold"}, bad, 1'b0);
    endtask

    initial begin
        logic [447:0] m56;
        int base;
        int eof_acc;
        int acc63;

        m56 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

        vecs[0] = '{pre: 64'h0, npre: 0, msg: 64'h0, n: 0, k: 0,
                    blk: {8'h80, 504'h0},
                    dig: 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, stall: -1};
        vecs[1] = '{pre: 64'h5500, npre: 2, msg: 64'h54455354, n: 4, k: 4,
                    blk: {32'h54455354, 8'h80, 408'h0, 64'h20},
                    dig: 256'h94ee059335e587e501cc4bf90613e0814f00a7b08bc7c648fd865a2af6a22cc2, stall: 5};
        vecs[2] = '{pre: 64'h0, npre: 0, msg: 64'h616263, n: 3, k: 3,
                    blk: {24'h616263, 8'h80, 416'h0, 64'h18},
                    dig: 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad, stall: -1};
        vecs[3] = '{pre: 64'h0, npre: 0, msg: 64'h0102, n: 2, k: 2,
                    blk: {16'h0102, 8'h80, 424'h0, 64'h10},
                    dig: 256'h00112233445566778899aabbccddeeff0123456789abcdef0f1e2d3c4b5a6978, stall: 31};
`ifdef SHA_FRAME_ESC_EN
        vecs[4] = '{pre: 64'h0, npre: 0, msg: 64'h617DDF62, n: 4, k: 3,
                    blk: {24'h61FF62, 8'h80, 416'h0, 64'h18},
                    dig: 256'hfedcba9876543210fedcba9876543210a5a5a5a55a5a5a5a1234567887654321, stall: 0};
`else
        vecs[4] = '{pre: 64'h0, npre: 0, msg: 64'h617DDF62, n: 4, k: 4,
                    blk: {32'h617DDF62, 8'h80, 408'h0, 64'h20},
                    dig: 256'hfedcba9876543210fedcba9876543210a5a5a5a55a5a5a5a1234567887654321, stall: 0};
`endif

        rst_n = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; inj_done = 1'b0;
        dig_in = 256'h0;
        rx_valid2 = 1'b0; rx_data2 = 8'h00; core_done2 = 1'b0; core_digest2 = 256'h0; tx_ready2 = 1'b1;

        // Reset values, then the first cycle after release.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {rx_ready, core_start, core_init, tx_valid, tx_data, busy, err}, 14'h0);
        chk("reset_blk", core_block, 512'h0);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("post_reset_ready", {rx_ready, busy}, 2'b10);

        // A stray core_done while idle must do nothing.
        inj_done = 1'b1;
        @(posedge clk); #1;
        inj_done = 1'b0;
        @(posedge clk); #1;
        chk("stray_done", {tx_valid, busy}, 2'b00);

        for (int v = 0; v < 5; v++) begin
            base   = n_start;
            dig_in = vecs[v].dig;
            for (int j = 0; j < vecs[v].npre; j++) send_byte(vecs[v].pre[8*(vecs[v].npre-1-j) +: 8]);
            if (vecs[v].npre > 0) chk($sformatf("v%0d_pre_ignored", v), {rx_ready, busy}, 2'b10);
            send_byte(8'h01);
            for (int j = 0; j < vecs[v].n; j++) send_byte(vecs[v].msg[8*(vecs[v].n-1-j) +: 8]);
            send_byte(8'hFF);
            eof_acc = last_acc;
            recv_digest($sformatf("v%0d", v), vecs[v].dig, vecs[v].stall);
            chk($sformatf("v%0d_nblk", v), n_start - base, 1);
            chk($sformatf("v%0d_init", v), init_cap[base], 1'b1);
            chk($sformatf("v%0d_blk", v), blk_cap[base], vecs[v].blk);
            chk($sformatf("v%0d_start_lat", v), start_cyc[base] - eof_acc, 64 - vecs[v].k);
        end

        // 64 bytes of 'a': full block from COLLECT, then a pure pad block.
        base   = n_start;
        dig_in = 256'hffeeddccbbaa99887766554433221100ffeeddccbbaa99887766554433221100;
        send_byte(8'h01);
        for (int j = 0; j < 64; j++) send_byte(8'h61);
        acc63 = last_acc;
        send_byte(8'hFF);
        recv_digest("a64", dig_in, -1);
        chk("a64_nblk", n_start - base, 2);
        chk("a64_start_lat", start_cyc[base] - acc63, 0);
        chk("a64_init", {init_cap[base], init_cap[base+1]}, 2'b10);
        chk("a64_blk0", blk_cap[base], {64{8'h61}});
        chk("a64_blk1", blk_cap[base+1], {8'h80, 440'h0, 64'h200});

        // 56-byte message: the 0x80 spills past byte 55, forcing a second block.
        base   = n_start;
        dig_in = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
        send_byte(8'h01);
        for (int j = 0; j < 56; j++) send_byte(m56[8*(55-j) +: 8]);
        send_byte(8'hFF);
        recv_digest("m56", dig_in, -1);
        chk("m56_nblk", n_start - base, 2);
        chk("m56_init", {init_cap[base], init_cap[base+1]}, 2'b10);
        chk("m56_blk0", blk_cap[base], {m56, 8'h80, 56'h0});
        chk("m56_blk1", blk_cap[base+1], {448'h0, 64'h1C0});

        // Reset in the middle of padding.
        base = n_start;
        send_byte(8'h01);
        send_byte(8'h41);
        send_byte(8'hFF);
        repeat (5) @(posedge clk);
        #1;
        chk("pad_busy", busy, 1'b1);
        #2 rst_n = 1'b1;
        #1;
        chk("midpad_rst_outs", {rx_ready, core_start, core_init, tx_valid, tx_data, busy, err}, 14'h0);
        chk("midpad_rst_blk", core_block, 512'h0);
        @(negedge clk); rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midpad_release", {rx_ready, busy}, 2'b10);
        repeat (80) @(posedge clk);
        #1;
        chk("midpad_no_start", n_start - base, 0);

        // Length overflow on a 4-bit-length instance: the 16th payload byte aborts.
        rx_valid2 = 1'b1;
        for (int j = 0; j < 17; j++) begin
            rx_data2 = (j == 0) ? 8'h01 : 8'h33;
            @(posedge clk); #1;
            if (j == 15) chk("ovf_busy_before", {busy2, err2}, 2'b10);
        end
        rx_valid2 = 1'b0;
        chk("ovf_err", {err2, busy2, rx_ready2}, 3'b101);
        @(posedge clk); #1;
        chk("ovf_err_pulse", err2, 1'b0);
        chk("ovf_no_start", start2_cnt, 0);

        chk("block_stable", stab_bad, 0);
        chk("no_err_main", err_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
